mem_stage_ctrl: RTL and testbench

- Consumer end of the execute-to-memory pipeline register.
- Takes the registered execute results, performs data-memory loads and stores through a req/ack handshake, and drives registered write-back results to the write-back stage.
- Asserts stall upstream so the execute-to-memory register holds its contents during a memory access.
- Non-memory instructions pass through with one-cycle latency and no stall.

---
 rtl/mem_stage_ctrl_pkg.sv | 16 +
 rtl/mem_stage_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_ctrl_pkg.sv
// mem_stage_ctrl_pkg
//   Shared definitions for the memory-stage controller: FSM state encoding,
//   default data/address widths and the register-index width.
package mem_stage_ctrl_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int ADDR_W_DEF = 9;
  localparam int REG_W      = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_WB   = 2'd2
  } mem_state_t;

endpackage

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl
//   Consumer end of the execute-to-memory pipeline register. Non-memory
//   instructions are forwarded to write-back one cycle after acceptance.
//   Loads and stores are issued through a req/ack handshake while the
//   upstream register is held by stall_out.
//
//   Optional build macro: MEM_TIMEOUT_EN
//     defined   - a BUSY access without ack for TIMEOUT_CYC cycles is aborted;
//                 write-back happens with WRegEn_out=0 and err_out pulses.
//     undefined - BUSY waits indefinitely; err_out is tied 0.
//
//   Ports
//     clk, reset        clock (rising edge), async active-low reset
//     valid_in          upstream register holds a live instruction
//     WRegEn_in         instruction writes the register file
//     WMemEn_in         store
//     MemRd_in          load
//     R1out_in          ALU result / memory address
//     R2out_in          store data
//     WReg1_in          destination register
//     stall_out         hold upstream register
//     mem_req/mem_we/mem_addr/mem_wdata   memory request
//     mem_ack/mem_rdata memory completion and load data
//     wb_valid, WRegEn_out, WReg1_out, WData_out   write-back outputs
//     err_out           one-cycle timeout pulse
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | accepting; ALU ops forwarded, memory ops latched and issued
//   BUSY  | mem_req held until mem_ack (or timeout)
//   WB    | write-back pulse; upstream still shows the finished instr
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  logic              WRegEn_in,
  input  logic              WMemEn_in,
  input  logic              MemRd_in,
  input  logic [DATA_W-1:0] R1out_in,
  input  logic [DATA_W-1:0] R2out_in,
  input  logic [REG_W-1:0]  WReg1_in,
  output logic              stall_out,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_valid,
  output logic              WRegEn_out,
  output logic [REG_W-1:0]  WReg1_out,
  output logic [DATA_W-1:0] WData_out,
  output logic              err_out
);

  mem_state_t        r_state,      w_state_nxt;
  logic              r_mem_req,    w_mem_req_nxt;
  logic              r_mem_we,     w_mem_we_nxt;
  logic [DATA_W-1:0] r_lat_addr,   w_lat_addr_nxt;
  logic [DATA_W-1:0] r_lat_wdata,  w_lat_wdata_nxt;
  logic [REG_W-1:0]  r_lat_dst,    w_lat_dst_nxt;
  logic              r_lat_wregen, w_lat_wregen_nxt;
  logic              r_lat_load,   w_lat_load_nxt;
  logic              r_wb_valid,   w_wb_valid_nxt;
  logic              r_wregen_out, w_wregen_out_nxt;
  logic [REG_W-1:0]  r_wreg1_out,  w_wreg1_out_nxt;
  logic [DATA_W-1:0] r_wdata_out,  w_wdata_out_nxt;
  logic              w_memop;

`ifdef MEM_TIMEOUT_EN
  localparam int TO_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  logic [TO_W-1:0] r_to_cnt, w_to_cnt_nxt;
  logic            r_err,    w_err_nxt;
`endif

  assign w_memop = valid_in & (WMemEn_in | MemRd_in);

  // Gated by reset so the upstream register is released while in reset,
  // even if it still presents a memory op.
  assign stall_out = reset & (((r_state == ST_IDLE) & w_memop) | (r_state == ST_BUSY));

  always_comb begin
    w_state_nxt      = r_state;
    w_mem_req_nxt    = r_mem_req;
    w_mem_we_nxt     = r_mem_we;
    w_lat_addr_nxt   = r_lat_addr;
    w_lat_wdata_nxt  = r_lat_wdata;
    w_lat_dst_nxt    = r_lat_dst;
    w_lat_wregen_nxt = r_lat_wregen;
    w_lat_load_nxt   = r_lat_load;
    w_wb_valid_nxt   = 1'b0;
    w_wregen_out_nxt = r_wregen_out;
    w_wreg1_out_nxt  = r_wreg1_out;
    w_wdata_out_nxt  = r_wdata_out;
`ifdef MEM_TIMEOUT_EN
    w_to_cnt_nxt     = r_to_cnt;
    w_err_nxt        = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_memop) begin
          w_state_nxt      = ST_BUSY;
          w_mem_req_nxt    = 1'b1;
          w_mem_we_nxt     = WMemEn_in;
          w_lat_addr_nxt   = R1out_in;
          w_lat_wdata_nxt  = R2out_in;
          w_lat_dst_nxt    = WReg1_in;
          w_lat_wregen_nxt = WRegEn_in;
          // store wins when both op bits are set
          w_lat_load_nxt   = ~WMemEn_in;
`ifdef MEM_TIMEOUT_EN
          w_to_cnt_nxt     = '0;
`endif
        end else if (valid_in) begin
          w_wb_valid_nxt   = 1'b1;
          w_wregen_out_nxt = WRegEn_in;
          w_wreg1_out_nxt  = WReg1_in;
          w_wdata_out_nxt  = R1out_in;
        end
      end
      ST_BUSY: begin
        if (mem_ack) begin
          w_state_nxt      = ST_WB;
          w_mem_req_nxt    = 1'b0;
          w_wb_valid_nxt   = 1'b1;
          w_wregen_out_nxt = r_lat_wregen;
          w_wreg1_out_nxt  = r_lat_dst;
          w_wdata_out_nxt  = r_lat_load ? mem_rdata : r_lat_addr;
        end
`ifdef MEM_TIMEOUT_EN
        // count hits TIMEOUT_CYC-1 on the TIMEOUT_CYC-th ack-less BUSY cycle
        else if (r_to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
          w_state_nxt      = ST_WB;
          w_mem_req_nxt    = 1'b0;
          w_wb_valid_nxt   = 1'b1;
          w_wregen_out_nxt = 1'b0;
          w_wreg1_out_nxt  = r_lat_dst;
          w_wdata_out_nxt  = r_lat_addr;
          w_err_nxt        = 1'b1;
        end else begin
          w_to_cnt_nxt     = r_to_cnt + 1'b1;
        end
`endif
      end
      ST_WB: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt   = ST_IDLE;
        w_mem_req_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_lat_addr   <= '0;
      r_lat_wdata  <= '0;
      r_lat_dst    <= '0;
      r_lat_wregen <= 1'b0;
      r_lat_load   <= 1'b0;
      r_wb_valid   <= 1'b0;
      r_wregen_out <= 1'b0;
      r_wreg1_out  <= '0;
      r_wdata_out  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_mem_req    <= w_mem_req_nxt;
      r_mem_we     <= w_mem_we_nxt;
      r_lat_addr   <= w_lat_addr_nxt;
      r_lat_wdata  <= w_lat_wdata_nxt;
      r_lat_dst    <= w_lat_dst_nxt;
      r_lat_wregen <= w_lat_wregen_nxt;
      r_lat_load   <= w_lat_load_nxt;
      r_wb_valid   <= w_wb_valid_nxt;
      r_wregen_out <= w_wregen_out_nxt;
      r_wreg1_out  <= w_wreg1_out_nxt;
      r_wdata_out  <= w_wdata_out_nxt;
    end
  end

`ifdef MEM_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_to_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      r_to_cnt <= w_to_cnt_nxt;
      r_err    <= w_err_nxt;
    end
  end
  assign err_out = r_err;
`else
  assign err_out = 1'b0;
`endif

  assign mem_req    = r_mem_req;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_lat_addr[ADDR_W-1:0];
  assign mem_wdata  = r_lat_wdata;
  assign wb_valid   = r_wb_valid;
  assign WRegEn_out = r_wregen_out;
  assign WReg1_out  = r_wreg1_out;
  assign WData_out  = r_wdata_out;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl
//   Directed bench for mem_stage_ctrl: reset, ALU pass-through, load with
//   wait states, store with immediate ack, a back-to-back stream, reset in
//   BUSY and (with MEM_TIMEOUT_EN) the timeout abort.
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in, WRegEn_in, WMemEn_in, MemRd_in;
  logic [63:0] R1out_in, R2out_in;
  logic [2:0]  WReg1_in;
  logic        stall_out, mem_req, mem_we;
  logic [8:0]  mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_ack;
  logic [63:0] mem_rdata;
  logic        wb_valid, WRegEn_out;
  logic [2:0]  WReg1_out;
  logic [63:0] WData_out;
  logic        err_out;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_stage_ctrl #(.DATA_W(64), .ADDR_W(9), .TIMEOUT_CYC(4)) dut (
    .clk(clk), .reset(reset),
    .valid_in(valid_in), .WRegEn_in(WRegEn_in), .WMemEn_in(WMemEn_in),
    .MemRd_in(MemRd_in), .R1out_in(R1out_in), .R2out_in(R2out_in),
    .WReg1_in(WReg1_in), .stall_out(stall_out),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .WRegEn_out(WRegEn_out), .WReg1_out(WReg1_out),
    .WData_out(WData_out), .err_out(err_out)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic we, input logic rd, input logic wr,
                       input logic [63:0] r1, input logic [63:0] r2, input logic [2:0] dst);
    valid_in  = v;
    WMemEn_in = we;
    MemRd_in  = rd;
    WRegEn_in = wr;
    R1out_in  = r1;
    R2out_in  = r2;
    WReg1_in  = dst;
  endtask

  // back-to-back stream: ALU, load, ALU
  task automatic drive_stream(input int idx);
    case (idx)
      0:       drive(1'b1, 1'b0, 1'b0, 1'b1, 64'h11, 64'h0, 3'd1);
      1:       drive(1'b1, 1'b0, 1'b1, 1'b1, 64'h20, 64'h0, 3'd4);
      2:       drive(1'b1, 1'b0, 1'b0, 1'b1, 64'h33, 64'h0, 3'd6);
      default: drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h0,  64'h0, 3'd0);
    endcase
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0]  exp_dst [3];
    logic [63:0] exp_dat [3];
    int          idx, k, waitc, nreq;
    logic        s, prev_req;

    exp_dst[0] = 3'd1; exp_dat[0] = 64'h11;
    exp_dst[1] = 3'd4; exp_dat[1] = 64'h77;
    exp_dst[2] = 3'd6; exp_dat[2] = 64'h33;

    reset     = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = 64'h0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 3'd0);
    #3;
    chk("rst_req",   mem_req,   0);
    chk("rst_stall", stall_out, 0);
    chk("rst_wbv",   wb_valid,  0);
    chk("rst_wdata", WData_out, 0);
    chk("rst_addr",  mem_addr,  0);
    chk("rst_err",   err_out,   0);
    #10 reset = 1'b1;
    step();

    // ALU op
    drive(1'b1, 1'b0, 1'b0, 1'b1, 64'h1234, 64'h0, 3'd3);
    #1 chk("alu_stall", stall_out, 0);
    step();
    chk("alu_wbv",   wb_valid,   1);
    chk("alu_wdata", WData_out,  64'h1234);
    chk("alu_dst",   WReg1_out,  3);
    chk("alu_wren",  WRegEn_out, 1);
    chk("alu_stall2", stall_out, 0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 3'd0);
    step();
    chk("idle_wbv",  wb_valid,  0);
    chk("idle_hold", WData_out, 64'h1234);

    // ack outside BUSY is ignored
    mem_ack = 1'b1;
    step();
    chk("stray_ack_req", mem_req,  0);
    chk("stray_ack_wbv", wb_valid, 0);
    mem_ack = 1'b0;

    // load, ack in third BUSY cycle
    drive(1'b1, 1'b0, 1'b1, 1'b1, 64'h010, 64'h0, 3'd5);
    #1 chk("ld_stall_idle", stall_out, 1);
    step();
    chk("ld_req1",   mem_req,   1);
    chk("ld_we",     mem_we,    0);
    chk("ld_addr",   mem_addr,  9'h010);
    chk("ld_wbv1",   wb_valid,  0);
    chk("ld_stall1", stall_out, 1);
    step();
    chk("ld_req2",   mem_req,   1);
    chk("ld_stall2", stall_out, 1);
    step();
    chk("ld_req3",   mem_req,   1);
    chk("ld_addr3",  mem_addr,  9'h010);
    mem_ack   = 1'b1;
    mem_rdata = 64'hDEAD_BEEF;
    step();
    mem_ack   = 1'b0;
    mem_rdata = 64'h0;
    chk("ld_wbv",   wb_valid,   1);
    chk("ld_wdata", WData_out,  64'hDEAD_BEEF);
    chk("ld_dst",   WReg1_out,  5);
    chk("ld_wren",  WRegEn_out, 1);
    chk("ld_req_wb", mem_req,   0);
    chk("ld_stall_wb", stall_out, 0);
    chk("ld_err",   err_out,    0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 3'd0);
    step();
    chk("ld_wbv_pulse", wb_valid, 0);

    // store with load bit also set; ack in first BUSY cycle
    drive(1'b1, 1'b1, 1'b1, 1'b0, 64'h5, 64'hAA, 3'd2);
    step();
    chk("st_req",   mem_req,   1);
    chk("st_we",    mem_we,    1);
    chk("st_wdata", mem_wdata, 64'hAA);
    chk("st_addr",  mem_addr,  9'h005);
    chk("st_wbv1",  wb_valid,  0);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("st_wbv",   wb_valid,   1);
    chk("st_wdata_out", WData_out, 64'h5);
    chk("st_wren",  WRegEn_out, 0);
    chk("st_req_wb", mem_req,   0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 3'd0);
    step();
    chk("st_req_after", mem_req,  0);
    chk("st_wbv_after", wb_valid, 0);

    // back-to-back ALU, load, ALU with the bench acting as upstream register
    idx = 0; k = 0; waitc = 0; nreq = 0; prev_req = 1'b0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      drive_stream(idx);
      if (mem_req) waitc++; else waitc = 0;
      mem_ack   = mem_req && (waitc >= 2);
      mem_rdata = 64'h77;
      @(negedge clk);
      s = stall_out;
      step();
      if (!s && idx < 3) idx++;
      if (mem_req && !prev_req) nreq++;
      prev_req = mem_req;
      if (wb_valid) begin
        if (k < 3) begin
          chk("b2b_dst",  WReg1_out, exp_dst[k]);
          chk("b2b_data", WData_out, exp_dat[k]);
        end
        k++;
      end
    end
    mem_ack = 1'b0;
    chk("b2b_count", k,    3);
    chk("b2b_nreq",  nreq, 1);
    chk("b2b_drain", idx,  3);

    // reset while BUSY
    drive(1'b1, 1'b0, 1'b1, 1'b1, 64'h40, 64'h0, 3'd7);
    step();
    chk("rb_req_pre", mem_req, 1);
    #2 reset = 1'b0;
    #1;
    chk("rb_req",   mem_req,   0);
    chk("rb_stall", stall_out, 0);
    chk("rb_wbv",   wb_valid,  0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 3'd0);
    #1 reset = 1'b1;
    step();
    chk("rb_idle_req",   mem_req,   0);
    chk("rb_idle_stall", stall_out, 0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 64'h99, 64'h0, 3'd1);
    step();
    chk("rb_alu_wbv",   wb_valid,  1);
    chk("rb_alu_wdata", WData_out, 64'h99);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 3'd0);
    step();

`ifdef MEM_TIMEOUT_EN
    // no ack: abort after 4 BUSY cycles
    drive(1'b1, 1'b0, 1'b1, 1'b1, 64'h30, 64'h0, 3'd3);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 3'd0);
    for (int i = 0; i < 3; i++) begin
      chk("to_req_busy", mem_req, 1);
      step();
    end
    chk("to_req_busy4", mem_req, 1);
    chk("to_err_busy4", err_out, 0);
    step();
    chk("to_req_drop", mem_req,    0);
    chk("to_wbv",      wb_valid,   1);
    chk("to_err",      err_out,    1);
    chk("to_wren",     WRegEn_out, 0);
    step();
    chk("to_err_pulse", err_out,  0);
    chk("to_wbv_pulse", wb_valid, 0);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
